// File: rtl/hd44780_write_sequencer.sv
// Drives one HD44780 4-bit-bus write (full byte or high nybble only): RS setup,
// one E pulse per nybble, E-low hold, then the post-write execution delay.
module hd44780_write_sequencer #(
  parameter int STATE_TIMER_BITS = 17,
  parameter int T_SETUP          = 3,
  parameter int T_EHIGH          = 24,
  parameter int T_ELOW           = 24,
  parameter int T_CMD            = 1800,
  parameter int T_LONG           = 73000
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [7:0]                  req_data,
  input  logic                        req_rs,
  input  logic                        req_nybble,
  input  logic                        req_long,
  output logic                        done_strobe,
  output logic                        tmr_start,
  output logic [STATE_TIMER_BITS-1:0] tmr_value,
  input  logic                        tmr_end,
  output logic                        lcd_rs,
  output logic                        lcd_e,
  output logic [3:0]                  lcd_data
);

  typedef enum logic [2:0] {
    IDLE, SETUP_H, EHIGH_H, ELOW_H, SETUP_L, EHIGH_L, ELOW_L, POST
  } state_t;

  localparam logic [STATE_TIMER_BITS-1:0] V_SETUP = STATE_TIMER_BITS'(T_SETUP);
  localparam logic [STATE_TIMER_BITS-1:0] V_EHIGH = STATE_TIMER_BITS'(T_EHIGH);
  localparam logic [STATE_TIMER_BITS-1:0] V_ELOW  = STATE_TIMER_BITS'(T_ELOW);
  localparam logic [STATE_TIMER_BITS-1:0] V_CMD   = STATE_TIMER_BITS'(T_CMD);
  localparam logic [STATE_TIMER_BITS-1:0] V_LONG  = STATE_TIMER_BITS'(T_LONG);

  state_t                        state_q;
  logic [3:0]                    lo_q;
  logic                          nyb_q;
  logic                          long_q;
  logic                          lcd_rs_q;
  logic                          lcd_e_q;
  logic [3:0]                    lcd_data_q;
  logic                          tmr_start_q;
  logic [STATE_TIMER_BITS-1:0]   tmr_value_q;
  logic                          adv;
  logic [STATE_TIMER_BITS-1:0]   post_val;

  // A tmr_end coinciding with our own load strobe belongs to the previous delay.
  assign adv       = tmr_end & ~tmr_start_q;
  assign post_val  = long_q ? V_LONG : V_CMD;

  assign req_ready   = RST_I & (state_q == IDLE);
  assign done_strobe = (state_q == POST) & adv;
  assign tmr_start   = tmr_start_q;
  assign tmr_value   = tmr_value_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_e       = lcd_e_q;
  assign lcd_data    = lcd_data_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      nyb_q       <= 1'b0;
      long_q      <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_data_q  <= '0;
      tmr_start_q <= 1'b0;
      tmr_value_q <= '0;
    end else begin
      tmr_start_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          lo_q        <= req_data[3:0];
          nyb_q       <= req_nybble;
          long_q      <= req_long;
          lcd_rs_q    <= req_rs;
          lcd_data_q  <= req_data[7:4];
          state_q     <= SETUP_H;
          tmr_start_q <= 1'b1;
          tmr_value_q <= V_SETUP;
        end
        SETUP_H: if (adv) begin
          state_q     <= EHIGH_H;
          lcd_e_q     <= 1'b1;
          tmr_start_q <= 1'b1;
          tmr_value_q <= V_EHIGH;
        end
        EHIGH_H: if (adv) begin
          state_q     <= ELOW_H;
          lcd_e_q     <= 1'b0;
          tmr_start_q <= 1'b1;
          tmr_value_q <= V_ELOW;
        end
        ELOW_H: if (adv) begin
          tmr_start_q <= 1'b1;
          if (nyb_q) begin
            state_q     <= POST;
            tmr_value_q <= post_val;
          end else begin
            // Low nybble goes out only here, with E already low for T_ELOW.
            state_q     <= SETUP_L;
            lcd_data_q  <= lo_q;
            tmr_value_q <= V_SETUP;
          end
        end
        SETUP_L: if (adv) begin
          state_q     <= EHIGH_L;
          lcd_e_q     <= 1'b1;
          tmr_start_q <= 1'b1;
          tmr_value_q <= V_EHIGH;
        end
        EHIGH_L: if (adv) begin
          state_q     <= ELOW_L;
          lcd_e_q     <= 1'b0;
          tmr_start_q <= 1'b1;
          tmr_value_q <= V_ELOW;
        end
        ELOW_L: if (adv) begin
          state_q     <= POST;
          tmr_start_q <= 1'b1;
          tmr_value_q <= post_val;
        end
        POST: if (adv) begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_write_sequencer.sv
// Directed bench for hd44780_write_sequencer with a behavioural state timer
// that holds each non-IDLE state for exactly its loaded number of clocks.
module tb_hd44780_write_sequencer;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        req_valid, req_ready;
  logic [7:0]  req_data;
  logic        req_rs, req_nybble, req_long;
  logic        done_strobe, tmr_start, tmr_end;
  logic [16:0] tmr_value;
  logic        lcd_rs, lcd_e;
  logic [3:0]  lcd_data;

  hd44780_write_sequencer dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_rs(req_rs), .req_nybble(req_nybble), .req_long(req_long),
    .done_strobe(done_strobe), .tmr_start(tmr_start), .tmr_value(tmr_value),
    .tmr_end(tmr_end), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 CLK_I = ~CLK_I;

  // Timer model: loaded at the edge that sees tmr_start, fires N-1 clocks later.
  logic [16:0] cnt;
  logic        armed;
  logic        inj;
  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (tmr_start) begin
      armed <= 1'b1;
      cnt   <= tmr_value - 17'd2;
    end else if (armed) begin
      if (cnt == 17'd0) armed <= 1'b0;
      else              cnt   <= cnt - 17'd1;
    end
  end
  assign tmr_end = (armed && cnt == 17'd0) || inj;

  // Monitor: append-only records; tests index them from a saved base.
  int   tv_q[$];
  int   ed_q[$];
  int   eh_q[$];
  int   done_cnt = 0, rs_bad = 0, viol = 0, ehi_cnt = 0;
  logic e_prev = 1'b0;
  logic [3:0] d_prev = 4'h0;
  logic exp_rs = 1'b0;
  always @(negedge CLK_I) begin
    if (!RST_I) begin
      e_prev  = 1'b0;
      ehi_cnt = 0;
    end else begin
      if (tmr_start) tv_q.push_back(int'(tmr_value));
      if (lcd_e && !e_prev) ed_q.push_back(int'(lcd_data));
      if (lcd_e) ehi_cnt++;
      if (!lcd_e && e_prev) begin eh_q.push_back(ehi_cnt); ehi_cnt = 0; end
      if (lcd_e && e_prev && lcd_data != d_prev) viol++;
      if (done_strobe) done_cnt++;
      if (!req_ready && lcd_rs != exp_rs) rs_bad++;
      e_prev = lcd_e;
      d_prev = lcd_data;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_I);
    #1;
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       nyb;
    logic       lng;
    logic       stale;
    int         ntmr;
    int         tv[7];
    int         npulse;
    int         ed[2];
  } vec_t;

  task automatic wait_done(output int leak, output bit got);
    leak = 0;
    got  = 1'b0;
    for (int t = 0; t < 80000 && !got; t++) begin
      if (done_strobe) got = 1'b1;
      else begin
        if (req_ready) leak++;
        tick();
      end
    end
  endtask

  task automatic do_write(input vec_t v);
    int tb0, eb0, hb0, db0, rb0, vb0, leak, t;
    bit got;
    tb0 = tv_q.size(); eb0 = ed_q.size(); hb0 = eh_q.size();
    db0 = done_cnt; rb0 = rs_bad; vb0 = viol;
    t = 0;
    while (!req_ready && t < 100) begin tick(); t++; end
    chk("ready_before", int'(req_ready), 1);
    exp_rs     = v.rs;
    req_data   = v.data;
    req_rs     = v.rs;
    req_nybble = v.nyb;
    req_long   = v.lng;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
    req_data   = ~v.data;
    req_rs     = ~v.rs;
    req_nybble = ~v.nyb;
    req_long   = ~v.lng;
    if (v.stale) begin
      chk("stale_start_seen", int'(tmr_start), 1);
      inj = 1'b1;
      tick();
      inj = 1'b0;
      chk("stale_e", int'(lcd_e), 0);
      chk("stale_restart", int'(tmr_start), 0);
    end
    wait_done(leak, got);
    chk("done_seen", int'(got), 1);
    chk("ready_leak", leak, 0);
    tick();
    chk("ready_after", int'(req_ready), 1);
    chk("done_count", done_cnt - db0, 1);
    chk("tmr_starts", tv_q.size() - tb0, v.ntmr);
    for (int i = 0; i < v.ntmr; i++) chk("tmr_value", qget(tv_q, tb0 + i), v.tv[i]);
    chk("e_pulses", ed_q.size() - eb0, v.npulse);
    for (int i = 0; i < v.npulse; i++) begin
      chk("e_data", qget(ed_q, eb0 + i), v.ed[i]);
      chk("e_len", qget(eh_q, hb0 + i), 24);
    end
    chk("rs_stable", rs_bad - rb0, 0);
    chk("data_vs_e", viol - vb0, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int leak, db0, eb0, vb0, t;
    bit got;
    vecs[0] = '{8'h48, 1'b1, 1'b0, 1'b0, 1'b0, 7, '{3, 24, 24, 3, 24, 24, 1800}, 2, '{4, 8}};
    vecs[1] = '{8'h30, 1'b0, 1'b1, 1'b0, 1'b0, 4, '{3, 24, 24, 1800, 0, 0, 0}, 1, '{3, 0}};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 7, '{3, 24, 24, 3, 24, 24, 73000}, 2, '{0, 1}};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 7, '{3, 24, 24, 3, 24, 24, 1800}, 2, '{5, 10}};

    RST_I = 1'b0; req_valid = 1'b0; req_data = 8'h00;
    req_rs = 1'b0; req_nybble = 1'b0; req_long = 1'b0; inj = 1'b0;
    repeat (3) tick();
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_tmr_start", int'(tmr_start), 0);
    chk("rst_tmr_value", int'(tmr_value), 0);
    chk("rst_done", int'(done_strobe), 0);
    RST_I = 1'b1;
    tick();
    chk("ready_out_of_reset", int'(req_ready), 1);

    // tmr_end while idle must not move the FSM
    inj = 1'b1;
    #1 chk("idle_inj_done", int'(done_strobe), 0);
    tick();
    inj = 1'b0;
    chk("idle_inj_ready", int'(req_ready), 1);
    chk("idle_inj_start", int'(tmr_start), 0);

    for (int i = 0; i < 4; i++) do_write(vecs[i]);

    // Back-to-back: valid held, data changed right after the first accept
    db0 = done_cnt; eb0 = ed_q.size(); vb0 = viol;
    exp_rs = 1'b1; req_rs = 1'b1; req_nybble = 1'b0; req_long = 1'b0;
    req_data = 8'h41; req_valid = 1'b1;
    tick();
    req_data = 8'h42;
    wait_done(leak, got);
    chk("b2b_done1", int'(got), 1);
    chk("b2b_ready_in_done", int'(req_ready), 0);
    tick();
    chk("b2b_ready_next", int'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_restart", int'(tmr_start), 1);
    chk("b2b_restart_val", int'(tmr_value), 3);
    chk("b2b_hi_nybble", int'(lcd_data), 4);
    wait_done(leak, got);
    chk("b2b_done2", int'(got), 1);
    tick();
    chk("b2b_done_cnt", done_cnt - db0, 2);
    chk("b2b_ed0", qget(ed_q, eb0 + 0), 4);
    chk("b2b_ed1", qget(ed_q, eb0 + 1), 1);
    chk("b2b_ed2", qget(ed_q, eb0 + 2), 4);
    chk("b2b_ed3", qget(ed_q, eb0 + 3), 2);
    chk("b2b_data_vs_e", viol - vb0, 0);

    // Reset in the middle of the second E pulse
    db0 = done_cnt; eb0 = ed_q.size();
    exp_rs = 1'b1; req_rs = 1'b1; req_data = 8'hA5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    t = 0;
    while (ed_q.size() < eb0 + 2 && t < 300) begin tick(); t++; end
    tick();
    chk("mid_ehigh_l", int'(lcd_e), 1);
    RST_I = 1'b0;
    #1;
    chk("async_e_drop", int'(lcd_e), 0);
    chk("async_ready", int'(req_ready), 0);
    chk("async_done", int'(done_strobe), 0);
    repeat (3) tick();
    chk("rst2_rs", int'(lcd_rs), 0);
    chk("rst2_data", int'(lcd_data), 0);
    chk("rst2_tmr_start", int'(tmr_start), 0);
    RST_I = 1'b1;
    tick();
    chk("rst2_ready", int'(req_ready), 1);
    repeat (30) tick();
    chk("rst2_no_done", done_cnt - db0, 0);
    do_write('{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 7, '{3, 24, 24, 3, 24, 24, 1800}, 2, '{5, 5}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hd44780_write_sequencer.md
Name: hd44780_write_sequencer

Overview:
- Sequences one HD44780 write (byte or single nybble) onto the 4-bit LCD bus: RS setup, E pulse per nybble, E-low hold, then post-command execution delay.
- All timing comes from the existing hd44780_state_timer via a start/value/end interface; this block owns no long counter.
- Sits between a higher-level LCD controller (init/text scheduler, requester side) and the LCD pins plus state timer.

Parameters:
- STATE_TIMER_BITS, 17, width of timer load value (must hold T_LONG).
- T_SETUP, 3, clocks RS/data stable before E rises (tAS ≥40 ns at 48 MHz).
- T_EHIGH, 24, clocks E held high (≥450 ns).
- T_ELOW, 24, clocks E low after each nybble, data held (≥500 ns).
- T_CMD, 1800, clocks post-write delay for normal commands and data (~37.5 µs).
- T_LONG, 73000, clocks post-write delay for clear/home (~1.52 ms).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  asynchronous, active-low reset.
- req_valid  in  1  requester has a write pending.
- req_ready  out  1  block accepts a request this cycle.
- req_data  in  8  byte to write. Nybble mode uses req_data[7:4] only.
- req_rs  in  1  RS level for this write (0 = command, 1 = data).
- req_nybble  in  1  send only the high nybble (init sequence).
- req_long  in  1  use T_LONG instead of T_CMD for the post delay.
- done_strobe  out  1  one-cycle pulse when the write, including its post delay, completes.
- tmr_start  out  1  one-cycle load strobe to the state timer.
- tmr_value  out  STATE_TIMER_BITS  delay to load; valid when tmr_start=1.
- tmr_end  in  1  one-cycle pulse from the timer when the delay expires.
- lcd_rs  out  1  LCD RS pin.
- lcd_e  out  1  LCD enable pin.
- lcd_data  out  4  LCD D7..D4.

Behaviour:
- States: IDLE, SETUP_H, EHIGH_H, ELOW_H, SETUP_L, EHIGH_L, ELOW_L, POST.
- Reset (RST_I=0, async): state=IDLE; lcd_e=0, lcd_rs=0, lcd_data=0, tmr_start=0, tmr_value=0, done_strobe=0. Mid-write reset drops E immediately and abandons the write, with no done_strobe.
- req_ready = (state==IDLE). This is combinational and is 0 while RST_I=0.
- Accept on the req_valid & req_ready edge:
  - Latch data, rs, nybble and long.
  - Next cycle: lcd_rs = latched rs, lcd_data = data[7:4], state=SETUP_H.
- Entry into every non-IDLE state pulses tmr_start for exactly 1 cycle with that state's delay:
  - SETUP_*: T_SETUP
  - EHIGH_*: T_EHIGH
  - ELOW_*: T_ELOW
  - POST: T_LONG if long, else T_CMD
- Each non-IDLE state waits for tmr_end. A tmr_end in the same cycle as this block's tmr_start is stale and ignored. tmr_end in IDLE is ignored.
- Transitions on tmr_end:
  - SETUP_H→EHIGH_H
  - EHIGH_H→ELOW_H
  - ELOW_H→SETUP_L, or POST if nybble
  - SETUP_L→EHIGH_L
  - EHIGH_L→ELOW_L
  - ELOW_L→POST
  - POST→IDLE, with done_strobe=1 in that transition cycle
- Registered outputs:
  - lcd_e=1 exactly while in EHIGH_H/EHIGH_L.
  - lcd_data switches to data[3:0] on entry to SETUP_L, never while lcd_e=1.
  - lcd_rs is constant from accept through POST and holds its value in IDLE.
- Back-to-back writes: req_ready is high the cycle after done_strobe. A new accept that cycle starts SETUP_H with no gap.
- Request inputs are don't-care except at the accept edge. Changes mid-write have no effect.
- Per-write timer starts: 7 for a full byte, 4 for nybble mode.

Test Plan:
- Byte write: req_data=0x48, rs=1, nybble=0, long=0 → lcd_rs=1 throughout. lcd_data=4 during first E pulse, 8 during second. Each E high is T_EHIGH clocks with an ideal timer. tmr_value sequence is 3,24,24,3,24,24,1800. One done_strobe.
- Nybble init: req_data=0x30, nybble=1 → single E pulse with lcd_data=3. Four tmr_start pulses, the last with value 1800. done_strobe follows.
- Long command: req_data=0x01, rs=0, long=1 → POST loads 73000. req_ready stays low until done_strobe.
- Back-to-back: req_valid held with 0x41 then 0x42 → second accept the cycle after the first done_strobe. lcd_e is never high while lcd_data changes.
- Reset mid-EHIGH_L: drive RST_I=0 → lcd_e=0 asynchronously, no done_strobe. After release, req_ready=1 and a new 0x55 write completes normally.
- Spurious tmr_end: pulse in IDLE and in the same cycle as tmr_start → no state change and no extra timer start.
